// File: rtl/shared_mem_arbiter_pkg.sv
// shared_mem_arbiter_pkg: memory-port encodings, sizes and FSM state type shared by the arbiter and the cores
package shared_mem_arbiter_pkg;
  localparam int CORE_COUNT = 4;
  localparam int REG_SIZE = 8;
  localparam int CORE_ID_SIZE = 2;
  localparam int ADDR_SIZE = CORE_ID_SIZE + REG_SIZE;
  localparam int MEM_DEPTH = 1 << ADDR_SIZE;
  localparam int IDX_SIZE = CORE_COUNT > 1 ? $clog2(CORE_COUNT) : 1;
  localparam logic [1:0] MEM_EN_NONE = 2'b00;
  localparam logic [1:0] MEM_EN_LD = 2'b01;
  localparam logic [1:0] MEM_EN_ST = 2'b10;
  typedef logic [REG_SIZE-1:0] reg_t;
  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [CORE_ID_SIZE-1:0] core_id_t;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  function automatic logic is_mem_req(input logic [1:0] en);
    return en == MEM_EN_LD || en == MEM_EN_ST;
  endfunction
endpackage

// File: rtl/shared_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at rr_ptr, plus the rr_ptr register
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         ptr_en,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);
  logic [W-1:0] rr_ptr;
  logic [W-1:0] cand [N];
  for (genvar k = 0; k < N; k++) begin : g_cand
    assign cand[k] = W'((int'(rr_ptr) + k) % N);
  end
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[cand[k]]) begin
        grant_valid = 1'b1;
        grant_idx = cand[k];
      end
  end
  always_ff @(posedge clk)
    if (reset) rr_ptr <= '0;
    else if (ptr_en) rr_ptr <= grant_idx == W'(N - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin LD/ST access from several cores into one single-port synchronous memory
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2*CORE_COUNT-1:0]        enable_bus,
  input  logic [ADDR_SIZE*CORE_COUNT-1:0] addr_bus,
  input  logic [REG_SIZE*CORE_COUNT-1:0] wr_data_bus,
  output logic [REG_SIZE*CORE_COUNT-1:0] rd_data_bus,
  output logic [CORE_COUNT-1:0]          ready_bus
);
  state_t state, state_nx;
  logic [CORE_COUNT-1:0] req;
  logic grant_valid, grab, mem_we, mem_re;
  logic [IDX_SIZE-1:0] grant_idx, win_q;
  logic [1:0] op_q;
  addr_t addr_q;
  reg_t data_q;
  reg_t mem [MEM_DEPTH];
  reg_t rd_q [CORE_COUNT];
  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_core
    assign req[i] = is_mem_req(enable_bus[2*i +: 2]);
    assign rd_data_bus[REG_SIZE*i +: REG_SIZE] = rd_q[i];
  end
  rr_arbiter #(.N(CORE_COUNT), .W(IDX_SIZE)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req),
    .ptr_en(grab),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (grant_valid ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  always_comb begin
    grab = state == IDLE && grant_valid;
    mem_we = state == ACCESS && op_q == MEM_EN_ST && !reset;
    mem_re = state == ACCESS && op_q == MEM_EN_LD;
  end
  always_ff @(posedge clk)
    if (reset) begin
      win_q <= '0;
      op_q <= MEM_EN_NONE;
      addr_q <= '0;
      data_q <= '0;
    end else if (grab) begin
      win_q <= grant_idx;
      op_q <= enable_bus[2*grant_idx +: 2];
      addr_q <= addr_bus[ADDR_SIZE*grant_idx +: ADDR_SIZE];
      data_q <= wr_data_bus[REG_SIZE*grant_idx +: REG_SIZE];
    end
  always_ff @(posedge clk)
    if (mem_we) mem[addr_q] <= data_q;
  always_ff @(posedge clk)
    if (reset) begin
      ready_bus <= '0;
      for (int i = 0; i < CORE_COUNT; i++) rd_q[i] <= '0;
    end else begin
      ready_bus <= state == ACCESS ? CORE_COUNT'(1) << win_q : '0;
      if (mem_re) rd_q[win_q] <= mem[addr_q];
    end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: directed scenarios with a per-core scoreboard of expected ready cycle and load data
module tb_shared_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] enable_bus;
  logic [39:0] addr_bus;
  logic [31:0] wr_data_bus;
  logic [31:0] rd_data_bus;
  logic [3:0] ready_bus;
  logic [1:0] en_r [4];
  logic [9:0] addr_r [4];
  logic [7:0] wd_r [4];
  typedef struct {int cyc; int core; bit ld; logic [7:0] data;} exp_t;
  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int mc, mi;
  shared_mem_arbiter dut (
    .clk(clk),
    .reset(reset),
    .enable_bus(enable_bus),
    .addr_bus(addr_bus),
    .wr_data_bus(wr_data_bus),
    .rd_data_bus(rd_data_bus),
    .ready_bus(ready_bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb
    for (int i = 0; i < 4; i++) begin
      enable_bus[2*i +: 2] = en_r[i];
      addr_bus[10*i +: 10] = addr_r[i];
      wr_data_bus[8*i +: 8] = wd_r[i];
    end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (ready_bus != 4'b0) begin
      check("onehot", 64'($countones(ready_bus)), 1);
      mc = 0;
      for (int i = 0; i < 4; i++) if (ready_bus[i]) mc = i;
      mi = -1;
      foreach (sb[k]) if (sb[k].core == mc) mi = k;
      if (mi < 0) check("spurious_ready", 64'(ready_bus), 0);
      else begin
        check("ready_cycle", 64'(cyc), 64'(sb[mi].cyc));
        if (sb[mi].ld) check("rd_data", 64'(rd_data_bus[8*mc +: 8]), 64'(sb[mi].data));
        sb.delete(mi);
      end
    end
  task automatic access(input int c, input logic [1:0] en, input logic [9:0] a, input logic [7:0] d, input int lat, input logic [7:0] exp_d);
    bit seen;
    exp_t e;
    e.cyc = cyc + lat;
    e.core = c;
    e.ld = en == 2'b01;
    e.data = exp_d;
    sb.push_back(e);
    en_r[c] = en;
    addr_r[c] = a;
    wd_r[c] = d;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = ready_bus[c];
    end
    if (!seen) check("timeout", 64'(seen), 1);
    @(posedge clk);
    #1;
    en_r[c] = 2'b00;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(ready_bus), 0);
    check("rst_rd_data", 64'(rd_data_bus), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      en_r[i] = 2'b00;
      addr_r[i] = '0;
      wd_r[i] = '0;
    end
    do_reset();
    access(0, 2'b10, 10'h105, 8'hA5, 2, 8'h00);
    access(0, 2'b10, 10'h2FF, 8'h11, 2, 8'h00);
    for (int i = 0; i < 4; i++) access(0, 2'b10, 10'(i), 8'(8'h40 + i), 2, 8'h00);
    access(1, 2'b01, 10'h105, 8'h00, 2, 8'hA5);
    access(0, 2'b10, 10'h010, 8'h3C, 2, 8'h00);
    access(0, 2'b01, 10'h010, 8'h00, 2, 8'h3C);
    do_reset();
    fork
      begin
        access(0, 2'b01, 10'h000, 8'h00, 2, 8'h40);
        access(0, 2'b01, 10'h000, 8'h00, 11, 8'h40);
      end
      access(1, 2'b01, 10'h001, 8'h00, 5, 8'h41);
      access(2, 2'b01, 10'h002, 8'h00, 8, 8'h42);
      access(3, 2'b01, 10'h003, 8'h00, 11, 8'h43);
    join
    access(2, 2'b01, 10'h002, 8'h00, 2, 8'h42);
    fork
      access(1, 2'b01, 10'h001, 8'h00, 5, 8'h41);
      access(3, 2'b01, 10'h003, 8'h00, 2, 8'h43);
    join
    fork
      access(0, 2'b01, 10'h000, 8'h00, 8, 8'h40);
      access(1, 2'b01, 10'h001, 8'h00, 11, 8'h41);
      access(2, 2'b01, 10'h002, 8'h00, 2, 8'h42);
      access(3, 2'b01, 10'h003, 8'h00, 5, 8'h43);
    join
    en_r[0] = 2'b11;
    addr_r[0] = 10'h105;
    wd_r[0] = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      check("illegal_ready", 64'(ready_bus), 0);
    end
    @(posedge clk);
    #1 en_r[0] = 2'b00;
    access(1, 2'b01, 10'h105, 8'h00, 2, 8'hA5);
    en_r[2] = 2'b10;
    addr_r[2] = 10'h2FF;
    wd_r[2] = 8'h77;
    @(posedge clk);
    #1 reset = 1'b1;
    en_r[2] = 2'b00;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(ready_bus), 0);
    check("abort_rd_data", 64'(rd_data_bus), 0);
    @(posedge clk);
    #1;
    fork
      access(0, 2'b01, 10'h2FF, 8'h00, 2, 8'h11);
      access(1, 2'b01, 10'h105, 8'h00, 5, 8'hA5);
    join
    repeat (4) @(posedge clk);
    check("sb_drain", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule
